// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the CPU front end: field widths, opcode
// field position inside the 16-bit instruction word, and load-phase encoding.
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 12;
    localparam int BYTE_W   = 8;
    localparam int WORD_W   = 2 * BYTE_W;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

    localparam logic LOAD_HI = 1'b0;
    localparam logic LOAD_LO = 1'b1;

    // The state encoding is the byte_phase output itself.
    typedef enum logic {
        ST_LOAD_HI = LOAD_HI,
        ST_LOAD_LO = LOAD_LO
    } load_state_e;

    function automatic logic [WORD_W-1:0] join_bytes(
        input logic [BYTE_W-1:0] hi,
        input logic [BYTE_W-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: two-flop synchronizer, optional debounce counter
// (enabled by INSTR_LOADER_DEBOUNCE_EN) and a rising-edge strobe.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic btn_edge_o,
    output logic deb_level_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic s1_q;
    logic s2_q;
    logic deb_lvl;
    logic deb_dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw_i;
            s2_q <= s1_q;
        end
    end

`ifdef INSTR_LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (s2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_lvl = deb_q;
`else
    assign deb_lvl = s2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_dly_q <= 1'b0;
        end else begin
            deb_dly_q <= deb_lvl;
        end
    end

    assign btn_edge_o  = deb_lvl & ~deb_dly_q;
    assign deb_level_o = deb_lvl;

endmodule

// File: rtl/instr_loader.sv
// Assembles a 16-bit instruction from two button-strobed switch bytes and
// hands opcode/instr to the core. Debounce enabled by INSTR_LOADER_DEBOUNCE_EN.
module instr_loader
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   data_in,
    input  logic                btn_raw,
    output logic [OPCODE_W-1:0] opcode,
    output logic [INSTR_W-1:0]  instr,
    output logic                inst_done,
    output logic                btn_edge,
    output logic                byte_phase
);

    logic                btn_edge_w;
    logic                deb_level;
    load_state_e         state_q;
    logic [BYTE_W-1:0]   hi_stage_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [INSTR_W-1:0]  instr_q;
    logic                done_q;
    logic [WORD_W-1:0]   word;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_i  (btn_raw),
        .btn_edge_o (btn_edge_w),
        .deb_level_o(deb_level)
    );

    assign word = join_bytes(hi_stage_q, data_in);

    // Outputs only move on the second press, so the core sees a stable word
    // while the next instruction's high byte is being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD_HI;
            hi_stage_q <= '0;
            opcode_q   <= '0;
            instr_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD_HI: begin
                    if (btn_edge_w) begin
                        hi_stage_q <= data_in;
                        state_q    <= ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (btn_edge_w) begin
                        opcode_q <= word[OPC_HI:OPC_LO];
                        instr_q  <= word[INSTR_W-1:0];
                        done_q   <= 1'b1;
                        state_q  <= ST_LOAD_HI;
                    end
                end
                default: state_q <= ST_LOAD_HI;
            endcase
        end
    end

    assign opcode     = opcode_q;
    assign instr      = instr_q;
    assign inst_done  = done_q;
    assign btn_edge   = btn_edge_w & (deb_level | ~deb_level);
    assign byte_phase = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: reset, table of full loads, bounce
// rejection (debounce build only), reset mid-load.
module tb_instr_loader;
  import cpu_pkg::*;

  localparam int N = 4;
`ifdef INSTR_LOADER_DEBOUNCE_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic btn_raw = 1'b0;
  logic [3:0] opcode;
  logic [11:0] instr;
  logic inst_done;
  logic btn_edge;
  logic byte_phase;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int done_cnt = 0;
  int dbl_done = 0;
  int f_seen = 0;
  int exp_done = 0;
  bit prev_done = 1'b0;
  bit watch_f = 1'b0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] opc;
    logic [11:0] ins;
  } vec_t;

  vec_t vecs[5];

  instr_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .btn_raw(btn_raw),
    .opcode(opcode),
    .instr(instr),
    .inst_done(inst_done),
    .btn_edge(btn_edge),
    .byte_phase(byte_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt += int'(btn_edge);
    done_cnt += int'(inst_done);
    if (prev_done && inst_done) dbl_done++;
    prev_done = inst_done;
    if (watch_f && opcode == 4'hF) f_seen++;
  endtask

  task automatic press(input logic [7:0] d, input bit lo, input logic [3:0] eo, input logic [11:0] ei);
    int first;
    int e0;
    logic [3:0] opc_before;
    logic [11:0] ins_before;
    first = -1;
    e0 = edge_cnt;
    opc_before = opcode;
    ins_before = instr;
    data_in = d;
    btn_raw = 1'b1;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      if (btn_edge && first < 0) begin
        first = i;
        check("done_before_update", inst_done, 0);
        check("opcode_before_update", opcode, opc_before);
      end else if (first >= 0 && i == first + 1) begin
        data_in = 8'($urandom_range(0, 255));
        if (lo) begin
          check("done_pulse", inst_done, 1);
          check("opcode", opcode, eo);
          check("instr", instr, ei);
        end else begin
          check("hold_opcode", opcode, opc_before);
          check("hold_instr", instr, ins_before);
          check("hold_done", inst_done, 0);
        end
      end
    end
    check("edge_latency", first, LAT);
    check("edge_once_held", edge_cnt - e0, 1);
    check("byte_phase", byte_phase, lo ? 0 : 1);
    btn_raw = 1'b0;
    repeat (LAT + 2) tick();
    check("no_release_edge", edge_cnt - e0, 1);
    if (lo) exp_done++;
  endtask

  initial begin
    int first;
    int e0;
    vecs[0] = '{8'hA3, 8'h5C, 4'hA, 12'h35C};
    vecs[1] = '{8'h12, 8'h34, 4'h1, 12'h234};
    vecs[2] = '{8'h80, 8'h01, 4'h8, 12'h001};
    vecs[3] = '{8'h7E, 8'hFF, 4'h7, 12'hEFF};
    vecs[4] = '{8'hC0, 8'h3F, 4'hC, 12'h03F};

    // Reset with the button held.
    rst_n = 1'b0;
    btn_raw = 1'b1;
    data_in = 8'h00;
    repeat (3) tick();
    check("rst_opcode", opcode, 0);
    check("rst_instr", instr, 0);
    check("rst_inst_done", inst_done, 0);
    check("rst_btn_edge", btn_edge, 0);
    check("rst_byte_phase", byte_phase, 0);
    check("rst_no_edges", edge_cnt, 0);

    rst_n = 1'b1;
    first = -1;
    e0 = edge_cnt;
    for (int i = 1; i <= LAT + 6; i++) begin
      tick();
      if (btn_edge && first < 0) first = i;
    end
    check("held_after_rst_latency", first, LAT);
    check("held_after_rst_once", edge_cnt - e0, 1);
    check("held_after_rst_phase", byte_phase, 1);
    btn_raw = 1'b0;
    repeat (LAT + 2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_pulse_phase", byte_phase, 0);
    check("rst_pulse_opcode", opcode, 0);

    // Table of full loads; each high press also checks output stability.
    for (int v = 0; v < 5; v++) begin
      press(vecs[v].hi, 1'b0, 4'h0, 12'h000);
      press(vecs[v].lo, 1'b1, vecs[v].opc, vecs[v].ins);
    end

`ifdef INSTR_LOADER_DEBOUNCE_EN
    e0 = edge_cnt;
    for (int w = 1; w < N; w++) begin
      btn_raw = 1'b1;
      repeat (w) tick();
      btn_raw = 1'b0;
      repeat (8) tick();
    end
    check("bounce_no_edge", edge_cnt - e0, 0);
    check("bounce_phase", byte_phase, 0);
    press(8'h00, 1'b0, 4'h0, 12'h000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("bounce_rst_phase", byte_phase, 0);
`endif

    // Reset between the two bytes must discard the staged high byte.
    watch_f = 1'b1;
    press(8'hFF, 1'b0, 4'h0, 12'h000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midload_phase", byte_phase, 0);
    check("midload_opcode", opcode, 0);
    check("midload_instr", instr, 0);
    check("midload_done", inst_done, 0);
    press(8'h21, 1'b0, 4'h0, 12'h000);
    press(8'h00, 1'b1, 4'h2, 12'h100);
    watch_f = 1'b0;
    check("midload_no_f_opcode", f_seen, 0);

    check("done_never_double", dbl_done, 0);
    check("done_total", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
